slink_pwr_seq: RTL and testbench
================================

// Module: slink_pwr_seq
// PURPOSE
// - Power/isolation sequencer that drives the Serial Link control interface: isolate_o, clk_ena_o, reset_no.
// - Consumes isolated_i back from the AXI isolation stages.
// - Brings the link up (clock on -> reset release -> de-isolate) and down (isolate -> reset assert -> clock off).
// - Sits in the always-on clk_i domain, between the register file request and the clock gate / reset mux / axi_isolate pair.
// PARAMETERS
// - NumIso         2     number of isolation channels (in/out AXI paths)
// - SettleCycles   8     cycles held in each clock/reset settle state; must be >= 1
// - TimeoutCycles  1024  max cycles waiting for isolated_i before forcing progress; must be >= 1
// PORTS
// - clk_i          in   1       always-on clock
// - rst_ni         in   1       asynchronous reset, active-low
// - up_req_i       in   1       level: 1 = link requested on, 0 = requested off
// - isolated_i     in   NumIso  isolation status per channel from axi_isolate
// - clr_timeout_i  in   1       single-cycle clear of the sticky timeout_o
// - isolate_o      out  NumIso  isolate request per channel (all bits always equal)
// - clk_ena_o      out  1       enable for the link clock gate
// - reset_no       out  1       link reset, active-low, synchronous to clk_i
// - busy_o         out  1       1 whenever state is not OFF and not ON
// - state_o        out  3       current FSM state encoding
// - timeout_o      out  1       sticky: an isolation wait hit TimeoutCycles
// BEHAVIOUR
// - One clock clk_i; rst_ni asynchronous active-low. All outputs are registered, decoded from the state register.
// - Reset values: state OFF, isolate_o all 1, clk_ena_o 0, reset_no 0, busy_o 0, timeout_o 0, counter 0.
// - States and outputs (isolate / clk_ena / reset_n):
//   - OFF=0 (1/0/0), CLK_ON=1 (1/1/0), RST_REL=2 (1/1/1), DEISO=3 (0/1/1)
//   - ON=4 (0/1/1), ISO=5 (1/1/1), RST_ASSERT=6 (1/1/0); code 7 is unused and returns to OFF
// - Transitions:
//   - OFF -> CLK_ON when up_req_i=1.
//   - CLK_ON -> RST_REL and RST_REL -> DEISO after exactly SettleCycles cycles in the state.
//   - DEISO -> ON the cycle after isolated_i == '0 is sampled.
//   - ON -> ISO when up_req_i=0.
//   - ISO -> RST_ASSERT the cycle after isolated_i == '1 is sampled.
//   - RST_ASSERT -> OFF after SettleCycles cycles.
// - up_req_i is sampled only in OFF and ON. Changes during a transition are ignored until a stable state is reached (no abort); the level present at that point then acts.
// - Counter:
//   - Width $clog2(max(SettleCycles,TimeoutCycles)+1); cleared on every state change, incremented otherwise, saturating at its max.
//   - Settle state exits when counter == SettleCycles-1.
// - Partial isolation (mixed isolated_i bits) counts as not done in both DEISO and ISO.
// - Latency, request sampled at cycle 0:
//   - Up: clk_ena_o=1 at cycle 1, reset_no=1 at 1+S, isolate_o=0 at 1+2S.
//   - Down: isolate_o=1 at cycle 1; reset_no=0 the cycle after isolation completes; clk_ena_o=0 S cycles later.
// - timeout_o:
//   - Set when clr_timeout_i and a set condition coincide: set wins.
//   - Cleared only by clr_timeout_i or rst_ni.
// - Reset asserted mid-sequence: all outputs take reset values immediately (asynchronously); no ordering guarantee during rst_ni.
// CONFIGURATION
// - `SLINK_PWR_SEQ_TIMEOUT_EN defined:
//   - In DEISO/ISO, when counter == TimeoutCycles-1 and isolation is not done, set timeout_o and advance (DEISO->ON, ISO->RST_ASSERT) next cycle.
// - Not defined:
//   - No timeout logic; DEISO/ISO wait indefinitely.
//   - timeout_o tied 0; clr_timeout_i unused.
// TESTING (SettleCycles=4, TimeoutCycles=16, NumIso=2; isolated_i model follows isolate_o with 2-cycle delay unless stated)
// 1. Reset, then release rst_ni:
//    -> isolate_o=2'b11, clk_ena_o=0, reset_no=0, state_o=0, busy_o=0, timeout_o=0.
// 2. up_req_i=1 at cycle 0:
//    -> clk_ena_o=1 @1, reset_no=1 @5, isolate_o=2'b00 @9, isolated_i=00 @11, state_o=4 and busy_o=0 @12.
// 3. From ON, up_req_i=0 at cycle 0:
//    -> isolate_o=11 @1, isolated_i=11 @3, reset_no=0 @4, clk_ena_o=0 and state_o=0 @8.
// 4. In ISO, hold isolated_i=2'b01:
//    -> with macro: timeout_o=1 and state_o=6 after 16 cycles; clr_timeout_i pulse -> timeout_o=0 next cycle.
//    -> without macro: stays in state 5, timeout_o=0.
// 5. up_req_i=1 at cycle 0, back to 0 at cycle 3:
//    -> sequence completes to ON @12, ISO entered @13.
// 6. Assert rst_ni in DEISO:
//    -> same cycle isolate_o=11, clk_ena_o=0, reset_no=0, state_o=0; after release with up_req_i=1, a full up sequence as in test 2.

Source files
------------

// File: rtl/slink_pwr_seq.sv
// slink_pwr_seq: serial link power/isolation sequencer (clock -> reset -> isolation ordering).
// Optional isolation-wait timeout enabled by `SLINK_PWR_SEQ_TIMEOUT_EN.
module slink_pwr_seq #(
  parameter int unsigned NumIso        = 2,
  parameter int unsigned SettleCycles  = 8,
  parameter int unsigned TimeoutCycles = 1024
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              up_req_i,
  input  logic [NumIso-1:0] isolated_i,
  input  logic              clr_timeout_i,
  output logic [NumIso-1:0] isolate_o,
  output logic              clk_ena_o,
  output logic              reset_no,
  output logic              busy_o,
  output logic [2:0]        state_o,
  output logic              timeout_o
);
  localparam int unsigned MaxCnt = SettleCycles > TimeoutCycles ? SettleCycles : TimeoutCycles;
  localparam int unsigned CntW   = $clog2(MaxCnt + 1);

  typedef enum logic [2:0] {
    OFF        = 3'd0,
    CLK_ON     = 3'd1,
    RST_REL    = 3'd2,
    DEISO      = 3'd3,
    ON         = 3'd4,
    ISO        = 3'd5,
    RST_ASSERT = 3'd6
  } state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            iso_q, iso_d, clk_ena_q, clk_ena_d, rst_n_q, rst_n_d;
  logic            busy_q, busy_d, timeout_q, timeout_d;
  logic            settled, all_iso, none_iso, to_hit, to_set;

  assign settled  = cnt_q == CntW'(SettleCycles - 1);
  assign all_iso  = &isolated_i;
  assign none_iso = ~|isolated_i;
`ifdef SLINK_PWR_SEQ_TIMEOUT_EN
  assign to_hit = cnt_q == CntW'(TimeoutCycles - 1);
`else
  assign to_hit = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    to_set  = 1'b0;
    case (state_q)
      OFF:        state_d = up_req_i ? CLK_ON : OFF;
      CLK_ON:     state_d = settled ? RST_REL : CLK_ON;
      RST_REL:    state_d = settled ? DEISO : RST_REL;
      DEISO: begin
        state_d = (none_iso || to_hit) ? ON : DEISO;
        to_set  = !none_iso && to_hit;
      end
      ON:         state_d = up_req_i ? ON : ISO;
      ISO: begin
        state_d = (all_iso || to_hit) ? RST_ASSERT : ISO;
        to_set  = !all_iso && to_hit;
      end
      RST_ASSERT: state_d = settled ? OFF : RST_ASSERT;
      default:    state_d = OFF;
    endcase
    cnt_d     = (state_d != state_q) ? '0 : (&cnt_q ? cnt_q : cnt_q + 1'b1);
    timeout_d = to_set | (timeout_q & ~clr_timeout_i);
    iso_d     = !(state_d inside {DEISO, ON});
    clk_ena_d = state_d != OFF;
    rst_n_d   = state_d inside {RST_REL, DEISO, ON, ISO};
    busy_d    = !(state_d inside {OFF, ON});
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= OFF;
      cnt_q     <= '0;
      iso_q     <= 1'b1;
      clk_ena_q <= 1'b0;
      rst_n_q   <= 1'b0;
      busy_q    <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      iso_q     <= iso_d;
      clk_ena_q <= clk_ena_d;
      rst_n_q   <= rst_n_d;
      busy_q    <= busy_d;
      timeout_q <= timeout_d;
    end
  end

  assign isolate_o = {NumIso{iso_q}};
  assign clk_ena_o = clk_ena_q;
  assign reset_no  = rst_n_q;
  assign busy_o    = busy_q;
  assign state_o   = state_q;
  assign timeout_o = timeout_q;
endmodule

// File: tb/tb_slink_pwr_seq.sv
// tb_slink_pwr_seq: table vectors, hand sequences and randomized run against a reference model.
module tb_slink_pwr_seq;
  localparam int S = 4;
  localparam int T = 16;
`ifdef SLINK_PWR_SEQ_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       up_req = 1'b0;
  logic       clr = 1'b0;
  logic       ovr = 1'b0;
  logic [1:0] ovr_val = 2'b00;
  logic [1:0] d1, d2, isolated;
  logic [1:0] isolate;
  logic       clk_ena, reset_n, busy, timeout;
  logic [2:0] state;
  int         checks = 0;
  int         failures = 0;

  always #5 clk = ~clk;

  slink_pwr_seq #(.NumIso(2), .SettleCycles(S), .TimeoutCycles(T)) dut (
    .clk_i(clk), .rst_ni(rst_n), .up_req_i(up_req), .isolated_i(isolated),
    .clr_timeout_i(clr), .isolate_o(isolate), .clk_ena_o(clk_ena), .reset_no(reset_n),
    .busy_o(busy), .state_o(state), .timeout_o(timeout)
  );

  // isolation stages respond two cycles after the request unless overridden
  always @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      d1 <= 2'b11;
      d2 <= 2'b11;
    end else begin
      d1 <= isolate;
      d2 <= d1;
    end
  assign isolated = ovr ? ovr_val : d2;

  // Reference model: state number plus time spent in it; outputs looked up per state.
  logic [2:0] outs [8];
  int m_st, m_age, nx;
  bit m_to, tset, up_done, dn_done, expire;
  initial outs = '{3'b100, 3'b110, 3'b111, 3'b011, 3'b011, 3'b111, 3'b110, 3'b100};
  always @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      m_st  <= 0;
      m_age <= 0;
      m_to  <= 1'b0;
    end else begin
      up_done = isolated == 2'b00;
      dn_done = isolated == 2'b11;
      expire  = TO_EN && m_age == T - 1;
      nx      = m_st;
      tset    = 1'b0;
      if (m_st == 0 && up_req) nx = 1;
      else if ((m_st == 1 || m_st == 2) && m_age == S - 1) nx = m_st + 1;
      else if (m_st == 3 && (up_done || expire)) begin nx = 4; tset = !up_done; end
      else if (m_st == 4 && !up_req) nx = 5;
      else if (m_st == 5 && (dn_done || expire)) begin nx = 6; tset = !dn_done; end
      else if (m_st == 6 && m_age == S - 1) nx = 0;
      m_st  <= nx;
      m_age <= (nx == m_st) ? m_age + 1 : 0;
      m_to  <= tset | (m_to & !clr);
    end

  typedef struct {
    int         at;
    bit         up;
    logic [2:0] st;
    logic [1:0] iso;
    bit         ce;
    bit         rn;
    bit         bz;
  } vec_t;
  vec_t tbl[13];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(string nm, logic [7:0] act, logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic chk_out(string tag, logic [2:0] st, logic [1:0] iso, bit ce, bit rn, bit bz, bit to);
    chk({tag, ".state"}, 8'(state), 8'(st));
    chk({tag, ".isolate"}, 8'(isolate), 8'(iso));
    chk({tag, ".clk_ena"}, 8'(clk_ena), 8'(ce));
    chk({tag, ".reset_n"}, 8'(reset_n), 8'(rn));
    chk({tag, ".busy"}, 8'(busy), 8'(bz));
    chk({tag, ".timeout"}, 8'(timeout), 8'(to));
  endtask

  task automatic run_table(string tag);
    int cur = 0;
    for (int r = 0; r < 13; r++) begin
      while (cur < tbl[r].at) begin
        tick();
        cur++;
      end
      chk_out($sformatf("%s@%0d", tag, tbl[r].at), tbl[r].st, tbl[r].iso, tbl[r].ce, tbl[r].rn, tbl[r].bz, 1'b0);
      up_req = tbl[r].up;
    end
  endtask

  task automatic wait_off(string tag);
    int n = 0;
    while (state !== 3'd0 && n < 60) begin
      tick();
      n++;
    end
    chk({tag, ".reach_off"}, 8'(state), 8'd0);
  endtask

  initial begin
    tbl[0]  = '{0,  1'b1, 3'd0, 2'b11, 1'b0, 1'b0, 1'b0};
    tbl[1]  = '{1,  1'b1, 3'd1, 2'b11, 1'b1, 1'b0, 1'b1};
    tbl[2]  = '{4,  1'b1, 3'd1, 2'b11, 1'b1, 1'b0, 1'b1};
    tbl[3]  = '{5,  1'b1, 3'd2, 2'b11, 1'b1, 1'b1, 1'b1};
    tbl[4]  = '{8,  1'b1, 3'd2, 2'b11, 1'b1, 1'b1, 1'b1};
    tbl[5]  = '{9,  1'b1, 3'd3, 2'b00, 1'b1, 1'b1, 1'b1};
    tbl[6]  = '{11, 1'b1, 3'd3, 2'b00, 1'b1, 1'b1, 1'b1};
    tbl[7]  = '{12, 1'b0, 3'd4, 2'b00, 1'b1, 1'b1, 1'b0};
    tbl[8]  = '{13, 1'b0, 3'd5, 2'b11, 1'b1, 1'b1, 1'b1};
    tbl[9]  = '{15, 1'b0, 3'd5, 2'b11, 1'b1, 1'b1, 1'b1};
    tbl[10] = '{16, 1'b0, 3'd6, 2'b11, 1'b1, 1'b0, 1'b1};
    tbl[11] = '{19, 1'b0, 3'd6, 2'b11, 1'b1, 1'b0, 1'b1};
    tbl[12] = '{20, 1'b0, 3'd0, 2'b11, 1'b0, 1'b0, 1'b0};

    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    run_table("updown");

    // up request withdrawn mid-sequence: completes to ON, then goes down
    up_req = 1'b1;
    repeat (3) tick();
    up_req = 1'b0;
    repeat (9) tick();
    chk("abort.state@12", 8'(state), 8'd4);
    tick();
    chk("abort.state@13", 8'(state), 8'd5);
    chk("abort.isolate@13", 8'(isolate), 8'h3);

    // partial isolation in ISO
    ovr = 1'b1;
    ovr_val = 2'b01;
    repeat (15) tick();
    chk("partial.state@15", 8'(state), 8'd5);
    chk("partial.timeout@15", 8'(timeout), 8'd0);
    tick();
    chk("partial.state@16", 8'(state), TO_EN ? 8'd6 : 8'd5);
    chk("partial.timeout@16", 8'(timeout), 8'(TO_EN));
    tick();
    chk("partial.sticky", 8'(timeout), 8'(TO_EN));
    clr = 1'b1;
    tick();
    clr = 1'b0;
    chk("partial.cleared", 8'(timeout), 8'd0);
    ovr = 1'b0;
    wait_off("partial");

    // asynchronous reset while in DEISO
    up_req = 1'b1;
    repeat (9) tick();
    chk("rst.pre_state", 8'(state), 8'd3);
    #2;
    rst_n = 1'b0;
    #1;
    chk_out("rst.async", 3'd0, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    rst_n = 1'b1;
    run_table("post_rst");

    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 15) == 0) up_req = ~up_req;
      clr = ($urandom_range(0, 7) == 0);
      if (ovr) begin
        if ($urandom_range(0, 3) == 0) ovr = 1'b0;
      end else if ($urandom_range(0, 30) == 0) begin
        ovr = 1'b1;
        ovr_val = 2'($urandom_range(0, 3));
      end
      tick();
      chk_out($sformatf("rand@%0d", i), 3'(m_st), {2{outs[m_st][2]}}, outs[m_st][1], outs[m_st][0],
              m_st != 0 && m_st != 4, m_to);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
    $fatal(1);
  end
endmodule
